bip_datapath_ext: RTL and testbench
===================================

Name: bip_datapath_ext

Overview:
- Next-generation BIP accumulator datapath, generalised in data width, operand width and opcode set.
- Adds logic and shift ops, a status-flag register, correct operand sign extension and an optional multi-cycle shift-add multiplier with a busy/done handshake.
- Sits between the BIP control unit (which drives select, write-enable and opcode) and data memory (which supplies i_data and receives o_data).
- The control unit must stall the PC while o_busy is high.

Parameters:
- NB_DATA, 16: accumulator, ALU and data-bus width (≥8).
- NB_OPERANDO, 11: immediate operand width (< NB_DATA).
- NB_OPCODE, 5: opcode width.
- NB_SEL_A, 2: accumulator-source select width.
- NB_SHAMT, 4: shift-amount bits taken from muxB LSBs (2^NB_SHAMT ≥ NB_DATA).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  synchronous reset, active-low.
- i_selA  in  NB_SEL_A  accumulator source: 00 i_data, 01 operand_ext, 10 ALU result, 11 hold.
- i_selB  in  1  ALU B operand: 0 i_data, 1 operand_ext.
- i_wrAcc  in  1  accumulator write enable.
- i_op  in  NB_OPCODE  ALU function.
- i_operando  in  NB_OPERANDO  instruction immediate.
- i_data  in  NB_DATA  memory read data.
- o_data  out  NB_DATA  accumulator value.
- o_flags  out  4  {Z,N,C,V} status register.
- o_busy  out  1  multi-cycle op in progress; writes are ignored while high.
- o_done  out  1  one-cycle pulse when a multi-cycle result is written.

Behaviour:
- Reset: when i_rst=0 at a rising edge: acc=0, flags=0, FSM=IDLE, counter=0, o_busy=0, o_done=0. Reset aborts an in-flight multiply; no result is written.
- operand_ext: sign-extended from i_operando[NB_OPERANDO-1] to NB_DATA.
- muxB: per i_selB.
- ALU (combinational, on acc and muxB):
  - 0010x ADD: acc+B.
  - 0011x SUB: acc−B.
  - 0100x AND.
  - 0101x OR.
  - 0110x XOR.
  - 01110 SHL: acc << B[NB_SHAMT-1:0].
  - 01111 SRA: arithmetic right shift by the same amount.
  - 1000x MUL: multi-cycle, see below.
  - Any other code: result 0.
  - Shift amounts ≥ NB_DATA give 0 (SHL) or all sign bits (SRA).
- Flags (single-cycle path):
  - Updated only on an edge where i_wrAcc=1, i_selA≠11 and FSM=IDLE.
  - Z = result==0; N = result MSB.
  - ADD: C = carry out, V = signed overflow.
  - SUB: C = NOT borrow, V = signed overflow.
  - Logic ops, shifts and loads (selA 00/01): C=0, V=0.
  - Otherwise flags hold.
- Accumulator (single-cycle path):
  - 1-cycle latency: on an edge with i_wrAcc=1 and FSM=IDLE, acc ← muxA (selA 11 holds).
  - o_data = acc (registered).
- Multiplier FSM: states IDLE, MUL, DONE.
  - IDLE→MUL when i_wrAcc=1, i_selA=10, i_op=1000x. Captures multiplicand=acc and multiplier=muxB, clears partial product, counter=0. acc is not written on the start edge.
  - MUL: each cycle, if multiplier LSB=1 add multiplicand to partial product (NB_DATA bits, low half kept); multiplicand<<=1; multiplier>>=1; counter++. Go to DONE after NB_DATA iterations.
  - DONE: o_done=1 for exactly one cycle. acc ← product low NB_DATA bits; Z/N from product; C=0; V=1 if the full signed product does not fit in NB_DATA bits (computed from the captured operands). Return to IDLE.
  - o_busy=1 in MUL and DONE. The result is visible on o_data NB_DATA+2 cycles after the start edge.
  - Any i_wrAcc or start request while o_busy=1 is ignored; flags hold.
- Simultaneous events: reset wins over everything. A start request in the cycle DONE→IDLE is ignored; a new start is accepted from the first IDLE cycle.

Optional Feature:
- Macro BIP_DATAPATH_MUL_EN.
- Defined: multiplier FSM, o_busy and o_done implemented as above.
- Undefined: no FSM or multiplier registers; opcodes 1000x behave as undefined (result 0, single-cycle, Z=1); o_busy and o_done tied 0.

Test Plan:
- Reset: drive i_rst=0 mid-stream with acc=0x1234 → next edge o_data=0x0000, o_flags=0000, o_busy=0.
- Sign extension: i_operando=11'h7FF, selA=01, wrAcc=1 → o_data=0xFFFF, Z=0, N=1. i_operando=11'h3FF → 0x03FF.
- ADD/SUB flags: acc=0x7FFF, ADD operand 1 (selB=1) → 0x8000, N=1, V=1, C=0. acc=0x0005, SUB i_data=5 → 0x0000, Z=1, C=1, V=0.
- Shifts: acc=0x8001, SRA by 1 → 0xC000. SHL by 15 → 0x8000. SRA by 16 (NB_SHAMT=5 variant) → 0xFFFF.
- Multiply (MUL_EN): acc=0x0007, MUL i_data=0xFFFD (−3) → o_busy high 18 cycles, o_done pulses once, o_data=0xFFEB, N=1, V=0. wrAcc loads issued during busy do not change acc.
- Multiply abort/overflow: acc=0x0100 × 0x0100 → 0x0000, Z=1, V=1. Repeat the multiply and assert i_rst=0 at cycle 8 → acc=0, FSM IDLE, no o_done pulse.

Source files
------------

// File: rtl/bip_datapath_ext_if.sv
// Bus between the BIP control unit / data memory and the accumulator datapath.
// The master side drives control and read data; the slave side is the datapath.
interface bip_datapath_ext_if #(
    parameter int NB_DATA     = 16,
    parameter int NB_OPERANDO = 11,
    parameter int NB_OPCODE   = 5,
    parameter int NB_SEL_A    = 2
);
    logic [NB_SEL_A-1:0]    i_selA;
    logic                   i_selB;
    logic                   i_wrAcc;
    logic [NB_OPCODE-1:0]   i_op;
    logic [NB_OPERANDO-1:0] i_operando;
    logic [NB_DATA-1:0]     i_data;
    logic [NB_DATA-1:0]     o_data;
    logic [3:0]             o_flags;
    logic                   o_busy;
    logic                   o_done;

    modport master (
        output i_selA, i_selB, i_wrAcc, i_op, i_operando, i_data,
        input  o_data, o_flags, o_busy, o_done
    );

    modport slave (
        input  i_selA, i_selB, i_wrAcc, i_op, i_operando, i_data,
        output o_data, o_flags, o_busy, o_done
    );
endinterface

// File: rtl/bip_datapath_ext.sv
// BIP accumulator datapath: ALU, {Z,N,C,V} flag register and accumulator.
// Define BIP_DATAPATH_MUL_EN to build the multi-cycle shift-add multiplier (busy/done handshake).
module bip_datapath_ext #(
    parameter int NB_DATA     = 16,
    parameter int NB_OPERANDO = 11,
    parameter int NB_OPCODE   = 5,
    parameter int NB_SEL_A    = 2,
    parameter int NB_SHAMT    = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    bip_datapath_ext_if.slave  bus
);
    localparam int MSB = NB_DATA - 1;

    localparam logic [NB_SEL_A-1:0] SEL_DATA = NB_SEL_A'(0);
    localparam logic [NB_SEL_A-1:0] SEL_IMM  = NB_SEL_A'(1);
    localparam logic [NB_SEL_A-1:0] SEL_ALU  = NB_SEL_A'(2);

    localparam logic [NB_OPCODE-2:0] OPH_ADD   = (NB_OPCODE-1)'(2);
    localparam logic [NB_OPCODE-2:0] OPH_SUB   = (NB_OPCODE-1)'(3);
    localparam logic [NB_OPCODE-2:0] OPH_AND   = (NB_OPCODE-1)'(4);
    localparam logic [NB_OPCODE-2:0] OPH_OR    = (NB_OPCODE-1)'(5);
    localparam logic [NB_OPCODE-2:0] OPH_XOR   = (NB_OPCODE-1)'(6);
    localparam logic [NB_OPCODE-2:0] OPH_SHIFT = (NB_OPCODE-1)'(7);

    logic [NB_DATA-1:0]   acc_q, acc_d;
    logic [3:0]           flags_q, flags_d;
    logic [NB_DATA-1:0]   operandExt;
    logic [NB_DATA-1:0]   muxB;
    logic [NB_DATA-1:0]   muxA;
    logic [NB_DATA-1:0]   aluRes;
    logic                 aluC, aluV, aluCvValid;
    logic [NB_DATA:0]     sumExt, diffExt;
    logic [NB_SHAMT-1:0]  shamt;
    logic [NB_OPCODE-2:0] opHi;
    logic                 opAdd, opSub, opAnd, opOr, opXor, opShl, opSra;
    logic                 loadSel;
    logic                 idle;
    logic                 start;
    logic                 writeOk;

    assign operandExt = {{(NB_DATA-NB_OPERANDO){bus.i_operando[NB_OPERANDO-1]}}, bus.i_operando};
    assign muxB       = bus.i_selB ? operandExt : bus.i_data;
    assign shamt      = muxB[NB_SHAMT-1:0];

    assign opHi  = bus.i_op[NB_OPCODE-1:1];
    assign opAdd = (opHi == OPH_ADD);
    assign opSub = (opHi == OPH_SUB);
    assign opAnd = (opHi == OPH_AND);
    assign opOr  = (opHi == OPH_OR);
    assign opXor = (opHi == OPH_XOR);
    assign opShl = (opHi == OPH_SHIFT) && !bus.i_op[0];
    assign opSra = (opHi == OPH_SHIFT) &&  bus.i_op[0];

    assign sumExt  = {1'b0, acc_q} + {1'b0, muxB};
    assign diffExt = {1'b0, acc_q} - {1'b0, muxB};

    // Shifts of NB_DATA or more naturally saturate to 0 / sign fill.
    always_comb begin
        aluRes     = '0;
        aluC       = 1'b0;
        aluV       = 1'b0;
        aluCvValid = 1'b0;
        if (opAdd) begin
            aluRes     = sumExt[MSB:0];
            aluC       = sumExt[NB_DATA];
            aluV       = (acc_q[MSB] == muxB[MSB]) && (sumExt[MSB] != acc_q[MSB]);
            aluCvValid = 1'b1;
        end else if (opSub) begin
            aluRes     = diffExt[MSB:0];
            aluC       = !diffExt[NB_DATA];
            aluV       = (acc_q[MSB] != muxB[MSB]) && (diffExt[MSB] != acc_q[MSB]);
            aluCvValid = 1'b1;
        end else if (opAnd) begin
            aluRes     = acc_q & muxB;
            aluCvValid = 1'b1;
        end else if (opOr) begin
            aluRes     = acc_q | muxB;
            aluCvValid = 1'b1;
        end else if (opXor) begin
            aluRes     = acc_q ^ muxB;
            aluCvValid = 1'b1;
        end else if (opShl) begin
            aluRes     = acc_q << shamt;
            aluCvValid = 1'b1;
        end else if (opSra) begin
            aluRes     = $signed(acc_q) >>> shamt;
            aluCvValid = 1'b1;
        end
    end

    always_comb begin
        muxA = acc_q;
        if (bus.i_selA == SEL_DATA) begin
            muxA = bus.i_data;
        end else if (bus.i_selA == SEL_IMM) begin
            muxA = operandExt;
        end else if (bus.i_selA == SEL_ALU) begin
            muxA = aluRes;
        end
    end

    assign loadSel = (bus.i_selA == SEL_DATA) || (bus.i_selA == SEL_IMM);
    assign writeOk = bus.i_wrAcc && idle && !start &&
                     (loadSel || (bus.i_selA == SEL_ALU));

`ifdef BIP_DATAPATH_MUL_EN
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;

    localparam int NB_CNT = $clog2(NB_DATA + 1);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NB_DATA);
    localparam logic [NB_OPCODE-2:0] OPH_MUL = (NB_OPCODE-1)'(8);

    state_t                   state_q, state_d;
    logic [NB_DATA-1:0]       mcand_q, mcand_d;
    logic [NB_DATA-1:0]       mplier_q, mplier_d;
    logic [NB_DATA-1:0]       prod_q, prod_d;
    logic [NB_DATA-1:0]       opA_q, opA_d;
    logic [NB_DATA-1:0]       opB_q, opB_d;
    logic [NB_CNT-1:0]        cnt_q, cnt_d;
    logic signed [2*NB_DATA-1:0] fullProd;
    logic                     mulOvf;

    assign idle  = (state_q == ST_IDLE);
    assign start = idle && bus.i_wrAcc && (bus.i_selA == SEL_ALU) && (opHi == OPH_MUL);

    // Overflow needs the full signed product, which the shift-add loop does not keep.
    assign fullProd = $signed(opA_q) * $signed(opB_q);
    assign mulOvf   = (fullProd != {{NB_DATA{fullProd[MSB]}}, fullProd[MSB:0]});

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_MUL;
                    mcand_d  = acc_q;
                    mplier_d = muxB;
                    opA_d    = acc_q;
                    opB_d    = muxB;
                    prod_d   = '0;
                    cnt_d    = '0;
                end
            end
            ST_MUL: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    if (mplier_q[0]) begin
                        prod_d = prod_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + NB_CNT'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            opA_q    <= '0;
            opB_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.o_busy = (state_q != ST_IDLE);
    assign bus.o_done = (state_q == ST_DONE);
`else
    assign idle       = 1'b1;
    assign start      = 1'b0;
    assign bus.o_busy = 1'b0;
    assign bus.o_done = 1'b0;
`endif

    // Undefined ALU opcodes leave C/V untouched; loads and defined ops replace them.
    always_comb begin
        acc_d   = acc_q;
        flags_d = flags_q;
        if (writeOk) begin
            acc_d      = muxA;
            flags_d[3] = (muxA == '0);
            flags_d[2] = muxA[MSB];
            if (loadSel) begin
                flags_d[1:0] = 2'b00;
            end else if (aluCvValid) begin
                flags_d[1:0] = {aluC, aluV};
            end
        end
`ifdef BIP_DATAPATH_MUL_EN
        if (state_q == ST_DONE) begin
            acc_d   = prod_q;
            flags_d = {(prod_q == '0), prod_q[MSB], 1'b0, mulOvf};
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            acc_q   <= '0;
            flags_q <= '0;
        end else begin
            acc_q   <= acc_d;
            flags_q <= flags_d;
        end
    end

    assign bus.o_data  = acc_q;
    assign bus.o_flags = flags_q;
endmodule

// File: tb/tb_bip_datapath_ext.sv
// Directed self-checking bench for bip_datapath_ext; multiplier cases build only with BIP_DATAPATH_MUL_EN.
module tb_bip_datapath_ext;
    localparam int NB_DATA     = 16;
    localparam int NB_OPERANDO = 11;
    localparam int NB_OPCODE   = 5;
    localparam int NB_SEL_A    = 2;
    localparam int NB_SHAMT    = 4;

    localparam logic [4:0] OP_NOP = 5'b00000;
    localparam logic [4:0] OP_ADD = 5'b00100;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_AND = 5'b01000;
    localparam logic [4:0] OP_OR  = 5'b01010;
    localparam logic [4:0] OP_XOR = 5'b01100;
    localparam logic [4:0] OP_SHL = 5'b01110;
    localparam logic [4:0] OP_SRA = 5'b01111;
    localparam logic [4:0] OP_MUL = 5'b10000;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    bip_datapath_ext_if #(
        .NB_DATA(NB_DATA), .NB_OPERANDO(NB_OPERANDO),
        .NB_OPCODE(NB_OPCODE), .NB_SEL_A(NB_SEL_A)
    ) bus ();

    bip_datapath_ext #(
        .NB_DATA(NB_DATA), .NB_OPERANDO(NB_OPERANDO), .NB_OPCODE(NB_OPCODE),
        .NB_SEL_A(NB_SEL_A), .NB_SHAMT(NB_SHAMT)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one instruction slot, clock it in and settle just after the edge.
    task automatic applyStimulus(input logic [1:0] selA, input logic selB, input logic wrAcc,
                                 input logic [4:0] op, input logic [10:0] operando,
                                 input logic [15:0] data);
        bus.i_selA     = selA;
        bus.i_selB     = selB;
        bus.i_wrAcc    = wrAcc;
        bus.i_op       = op;
        bus.i_operando = operando;
        bus.i_data     = data;
        @(posedge clk);
        #1;
    endtask

    task automatic loadData(input logic [15:0] data);
        applyStimulus(2'b00, 1'b0, 1'b1, OP_NOP, 11'h000, data);
    endtask

`ifdef BIP_DATAPATH_MUL_EN
    // Keeps clocking while busy, optionally hammering accumulator loads that must be ignored.
    task automatic waitMul(input logic hammer, output int busyCycles, output int doneCycles,
                           output logic [15:0] dataAtDone);
        busyCycles = bus.o_busy ? 1 : 0;
        doneCycles = 0;
        dataAtDone = 16'hDEAD;
        bus.i_selA  = 2'b00;
        bus.i_data  = 16'h1111;
        bus.i_wrAcc = hammer;
        for (int i = 0; i < 40 && bus.o_busy; i++) begin
            if (bus.o_done) begin
                doneCycles++;
                dataAtDone = bus.o_data;
            end
            @(posedge clk);
            #1;
            if (bus.o_busy) busyCycles++;
        end
        bus.i_wrAcc = 1'b0;
    endtask
`endif

    initial begin
        int          busyCycles;
        int          doneCycles;
        logic [15:0] dataAtDone;
        errors = 0;
        checks = 0;
        rst = 1'b0;
        bus.i_selA = '0; bus.i_selB = 1'b0; bus.i_wrAcc = 1'b0;
        bus.i_op = '0; bus.i_operando = '0; bus.i_data = '0;

        applyStimulus(2'b00, 1'b0, 1'b0, OP_NOP, 11'h000, 16'h0000);
        applyStimulus(2'b00, 1'b0, 1'b0, OP_NOP, 11'h000, 16'h0000);
        checkOutput("reset_data", 32'(bus.o_data), 32'h0000);
        checkOutput("reset_flags", 32'(bus.o_flags), 32'h0);
        checkOutput("reset_busy", 32'(bus.o_busy), 32'h0);
        checkOutput("reset_done", 32'(bus.o_done), 32'h0);
        rst = 1'b1;

        loadData(16'h1234);
        checkOutput("load_data", 32'(bus.o_data), 32'h1234);
        applyStimulus(2'b10, 1'b0, 1'b1, OP_ADD, 11'h000, 16'h7000);
        checkOutput("add_ovf_data", 32'(bus.o_data), 32'h8234);
        checkOutput("add_ovf_flags", 32'(bus.o_flags), 32'b0101);

        rst = 1'b0;
        loadData(16'h5555);
        rst = 1'b1;
        checkOutput("midreset_data", 32'(bus.o_data), 32'h0000);
        checkOutput("midreset_flags", 32'(bus.o_flags), 32'h0);

        applyStimulus(2'b01, 1'b0, 1'b1, OP_NOP, 11'h7FF, 16'h0000);
        checkOutput("sext_neg_data", 32'(bus.o_data), 32'hFFFF);
        checkOutput("sext_neg_flags", 32'(bus.o_flags), 32'b0100);
        applyStimulus(2'b01, 1'b0, 1'b1, OP_NOP, 11'h3FF, 16'h0000);
        checkOutput("sext_pos_data", 32'(bus.o_data), 32'h03FF);
        applyStimulus(2'b00, 1'b0, 1'b0, OP_NOP, 11'h000, 16'hAAAA);
        checkOutput("wr_disabled", 32'(bus.o_data), 32'h03FF);

        loadData(16'h7FFF);
        applyStimulus(2'b10, 1'b1, 1'b1, OP_ADD, 11'h001, 16'h0000);
        checkOutput("add_imm_data", 32'(bus.o_data), 32'h8000);
        checkOutput("add_imm_flags", 32'(bus.o_flags), 32'b0101);
        applyStimulus(2'b11, 1'b0, 1'b1, OP_ADD, 11'h000, 16'h1234);
        checkOutput("hold_data", 32'(bus.o_data), 32'h8000);
        checkOutput("hold_flags", 32'(bus.o_flags), 32'b0101);

        loadData(16'h0005);
        applyStimulus(2'b10, 1'b0, 1'b1, OP_SUB, 11'h000, 16'h0005);
        checkOutput("sub_zero_data", 32'(bus.o_data), 32'h0000);
        checkOutput("sub_zero_flags", 32'(bus.o_flags), 32'b1010);
        applyStimulus(2'b10, 1'b1, 1'b1, OP_SUB, 11'h001, 16'h0000);
        checkOutput("sub_borrow_data", 32'(bus.o_data), 32'hFFFF);
        checkOutput("sub_borrow_flags", 32'(bus.o_flags), 32'b0100);
        applyStimulus(2'b10, 1'b0, 1'b1, OP_ADD, 11'h000, 16'h0001);
        checkOutput("add_carry_data", 32'(bus.o_data), 32'h0000);
        checkOutput("add_carry_flags", 32'(bus.o_flags), 32'b1010);
        applyStimulus(2'b10, 1'b0, 1'b1, OP_AND, 11'h000, 16'hFFFF);
        checkOutput("and_clear_cv_flags", 32'(bus.o_flags), 32'b1000);

        loadData(16'hF0F0);
        applyStimulus(2'b10, 1'b0, 1'b1, OP_AND, 11'h000, 16'h3C3C);
        checkOutput("and_data", 32'(bus.o_data), 32'h3030);
        applyStimulus(2'b10, 1'b0, 1'b1, OP_OR, 11'h000, 16'h0F00);
        checkOutput("or_data", 32'(bus.o_data), 32'h3F30);
        applyStimulus(2'b10, 1'b1, 1'b1, OP_XOR, 11'h7FF, 16'h0000);
        checkOutput("xor_data", 32'(bus.o_data), 32'hC0CF);
        checkOutput("xor_flags", 32'(bus.o_flags), 32'b0100);

        loadData(16'h8001);
        applyStimulus(2'b10, 1'b1, 1'b1, OP_SRA, 11'h001, 16'h0000);
        checkOutput("sra1_data", 32'(bus.o_data), 32'hC000);
        loadData(16'h0001);
        applyStimulus(2'b10, 1'b1, 1'b1, OP_SHL, 11'h00F, 16'h0000);
        checkOutput("shl15_data", 32'(bus.o_data), 32'h8000);
        checkOutput("shl15_flags", 32'(bus.o_flags), 32'b0100);
        applyStimulus(2'b10, 1'b1, 1'b1, OP_SRA, 11'h00F, 16'h0000);
        checkOutput("sra15_data", 32'(bus.o_data), 32'hFFFF);
        applyStimulus(2'b10, 1'b1, 1'b1, OP_SHL, 11'h011, 16'h0000);
        checkOutput("shamt_lsbs_data", 32'(bus.o_data), 32'hFFFE);

        loadData(16'h0042);
        applyStimulus(2'b10, 1'b0, 1'b1, OP_NOP, 11'h000, 16'h0003);
        checkOutput("undef_op_data", 32'(bus.o_data), 32'h0000);
        checkOutput("undef_op_zn", 32'(bus.o_flags[3:2]), 32'b10);

`ifdef BIP_DATAPATH_MUL_EN
        loadData(16'h0007);
        applyStimulus(2'b10, 1'b0, 1'b1, OP_MUL, 11'h000, 16'hFFFD);
        checkOutput("mul_start_nowrite", 32'(bus.o_data), 32'h0007);
        waitMul(1'b1, busyCycles, doneCycles, dataAtDone);
        checkOutput("mul_busy_cycles", 32'(busyCycles), 32'd18);
        checkOutput("mul_done_pulses", 32'(doneCycles), 32'd1);
        checkOutput("mul_loads_ignored", 32'(dataAtDone), 32'h0007);
        checkOutput("mul_neg_data", 32'(bus.o_data), 32'hFFEB);
        checkOutput("mul_neg_flags", 32'(bus.o_flags), 32'b0100);

        loadData(16'h0100);
        applyStimulus(2'b10, 1'b0, 1'b1, OP_MUL, 11'h000, 16'h0100);
        waitMul(1'b0, busyCycles, doneCycles, dataAtDone);
        checkOutput("mul_ovf_data", 32'(bus.o_data), 32'h0000);
        checkOutput("mul_ovf_flags", 32'(bus.o_flags), 32'b1001);

        loadData(16'h0100);
        applyStimulus(2'b10, 1'b0, 1'b1, OP_MUL, 11'h000, 16'h0100);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(2'b00, 1'b0, 1'b0, OP_NOP, 11'h000, 16'h0000);
        end
        rst = 1'b0;
        applyStimulus(2'b00, 1'b0, 1'b0, OP_NOP, 11'h000, 16'h0000);
        rst = 1'b1;
        checkOutput("abort_data", 32'(bus.o_data), 32'h0000);
        checkOutput("abort_busy", 32'(bus.o_busy), 32'h0);
        doneCycles = 0;
        for (int i = 0; i < 25; i++) begin
            applyStimulus(2'b00, 1'b0, 1'b0, OP_NOP, 11'h000, 16'h0000);
            if (bus.o_done) doneCycles++;
        end
        checkOutput("abort_no_done", 32'(doneCycles), 32'd0);
        checkOutput("abort_data_stays", 32'(bus.o_data), 32'h0000);
`else
        loadData(16'hFFFE);
        applyStimulus(2'b10, 1'b0, 1'b1, OP_MUL, 11'h000, 16'h0003);
        checkOutput("nomul_data", 32'(bus.o_data), 32'h0000);
        checkOutput("nomul_zn", 32'(bus.o_flags[3:2]), 32'b10);
        checkOutput("nomul_busy", 32'(bus.o_busy), 32'h0);
        checkOutput("nomul_done", 32'(bus.o_done), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
